// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared 7-segment definitions: segment bit positions within the
//             {a,b,c,d,e,f,g} bus, the hex-to-segment table (active-high) and
//             an encode helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Bit positions of each segment in the 7-bit bus; a is the MSB.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-high segment patterns for hex digits 0..F, ordered {a..g}.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seven_seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_driver_if
//  Purpose  : Bundle between the datapath and the scanning display driver.
//  Signals  : load       - one-cycle strobe capturing digits_in/dp_in
//             digits_in  - 4*NUM_DIGITS hex values, digit 0 rightmost
//             dp_in      - decimal point per digit
//             blank_lz   - suppress leading zeros
//             seg        - segments {a..g}
//             dp         - decimal point of the scanned digit
//             an         - digit anode enables
//             frame_done - pulse on the last cycle of the last digit slot
//  Modports : master (value source / display sink), slave (driver)
//  Revision : 1.0  initial release
// ============================================================================
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank_lz;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, digits_in, dp_in, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, digits_in, dp_in, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface : seven_seg_scan_driver_if
`default_nettype wire

// File: rtl/seven_seg_scan_driver_hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_seg7
//  Purpose  : Combinational nibble to 7-segment decoder (active-high).
//  Ports    : nibble_i [3:0] - hex value
//             seg_o    [6:0] - segments {a,b,c,d,e,f,g}, a = bit 6
//  Revision : 1.0  initial release
// ============================================================================
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [6:0] enc;

  assign enc = seg7_encode(nibble_i);

  // Pin the output to the board's {a..g} order through the named positions,
  // so a change in table bit layout cannot silently reorder the pins.
  assign seg_o = {enc[SEG_A], enc[SEG_B], enc[SEG_C], enc[SEG_D],
                  enc[SEG_E], enc[SEG_F], enc[SEG_G]};

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_driver
//  Purpose  : Time-multiplexed N-digit hex 7-segment driver with refresh
//             scanning, anti-ghost blanking, optional leading-zero
//             suppression and frame-synchronous (tear-free) value updates.
//  Ports    : clk  - system clock
//             rst  - synchronous reset, active-high
//             bus  - seven_seg_scan_driver_if.slave (load, digits_in, dp_in,
//                    blank_lz in; seg, dp, an, frame_done out)
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GHOST_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  seven_seg_scan_driver_if.slave   bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0]      GHOST_END = DIV_W'(GHOST_CYCLES);
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // ---------------------------------------------------------------- state
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, disp_dig_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q,  disp_dp_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  logic                    slot_end;
  logic                    frame_end;

  // ------------------------------------------------------ divider / scanner
  always_comb begin
    slot_end  = (div_q == DIV_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    div_d     = slot_end ? '0 : div_q + DIV_W'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // ------------------------------------------------ leading-zero detection
  // lz_mask[k] = 1 when display digits NUM_DIGITS-1..k are all zero; digit 0
  // is never a leading zero so its bit is tied low.
  logic [NUM_DIGITS-1:0] lz_mask;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    if (k == 0) begin : g_lz_units
      assign lz_mask[k] = 1'b0;
    end else if (k == NUM_DIGITS - 1) begin : g_lz_top
      assign lz_mask[k] = (disp_dig_q[4*k +: 4] == 4'h0);
    end else begin : g_lz_mid
      assign lz_mask[k] = lz_mask[k+1] && (disp_dig_q[4*k +: 4] == 4'h0);
    end
  end

  // ------------------------------------------------------ digit mux/decode
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic       cur_blank;

  assign cur_nib   = disp_dig_q[{idx_q, 2'b00} +: 4];
  assign cur_blank = bus.blank_lz && lz_mask[idx_q];

  hex_to_seg7 u_dec (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

  // ------------------------------------------------- next output values
  always_comb begin
    an_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = (idx_q == IDX_W'(k));
    end
    if (AN_ACTIVE_LOW) begin
      an_d = ~an_d;
    end
    // Anodes stay off at the start of each slot so the previous digit's
    // segment pattern cannot bleed onto the newly selected digit.
    if (div_q < GHOST_END) begin
      an_d = AN_OFF;
    end

    if (cur_blank) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
    end
    dp_d = SEG_ACTIVE_LOW ? ~disp_dp_q[idx_q] : disp_dp_q[idx_q];
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      disp_dig_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;

      if (bus.load) begin
        pend_dig_q <= bus.digits_in;
        pend_dp_q  <= bus.dp_in;
      end

      // Display only changes at the frame boundary; a load on that very
      // cycle bypasses the pending register so it is not a frame late.
      if (frame_end) begin
        disp_dig_q <= bus.load ? bus.digits_in : pend_dig_q;
        disp_dp_q  <= bus.load ? bus.dp_in     : pend_dp_q;
      end

      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;

      // Registered from the next state so the pulse coincides with the
      // last cycle of the last slot, i.e. the cycle on which a load commits
      // straight to the display.
      frame_done_q <= (div_d == DIV_LAST) && (idx_d == IDX_LAST);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule : seven_seg_scan_driver
`default_nettype wire

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Parametrised, time-multiplexed multi-digit 7-segment display driver.
- Successor to the single-digit 4-bit-to-segment decoder: it generalises to N hex digits with per-digit decimal points.
- Adds refresh scanning, anti-ghost blanking, optional leading-zero suppression and tear-free frame-synchronous updates.
- Sits between the datapath, which supplies values, and the board's shared-segment / per-digit-anode display.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles each digit slot lasts (>= 2).
- GHOST_CYCLES, 16, cycles at start of each slot with all anodes off (< REFRESH_DIV).
- SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light.
- AN_ACTIVE_LOW, 1, 1 = anode low selects digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- load  in  1  one-cycle strobe to capture digits_in/dp_in.
- digits_in  in  4*NUM_DIGITS  hex values; digit k in bits [4k+3:4k], digit 0 = rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank_lz  in  1  1 = suppress leading zeros.
- seg  out  7  segments {a,b,c,d,e,f,g}, a = bit 6.
- dp  out  1  decimal point of current digit.
- an  out  NUM_DIGITS  digit enables.
- frame_done  out  1  one-cycle pulse at end of last digit slot.

Behaviour:
- Reset: all of the following are cleared, and all outputs are registered.
  - div counter, scan index, pending and display registers = 0.
  - an = all inactive, seg/dp = unlit, frame_done = 0.
- Divider:
  - div counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1, div wraps to 0 and idx advances (idx = NUM_DIGITS-1 wraps to 0).
- Output timing: outputs reflect the (div, idx) state one cycle earlier (1-cycle latency).
- Anti-ghosting: an = all inactive while registered div < GHOST_CYCLES. Otherwise only bit idx of an is active.
- seg/dp: driven for digit idx throughout the slot, including the ghost window.
- Decode: standard hex table, active-high form shown.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - Output is inverted when SEG_ACTIVE_LOW.
- Load:
  - On load, pending <= {digits_in, dp_in}.
  - Multiple loads within one frame: the last one wins.
- Frame commit:
  - frame_done = 1 for the cycle where div = REFRESH_DIV-1 and idx = NUM_DIGITS-1.
  - On that cycle, display <= pending, or <= digits_in/dp_in directly if load is coincident.
  - The displayed value never changes mid-frame.
- Leading-zero blanking, when blank_lz = 1:
  - Digit k is blanked (seg unlit) if display digits NUM_DIGITS-1..k are all zero and k != 0.
  - Digit 0 is never blanked.
  - dp is still driven for blanked digits.
  - blank_lz is sampled combinationally into the registered output, so it takes effect on the next cycle.
- Reset mid-frame: the state resets on the next edge; any pending load is discarded.
- NUM_DIGITS = 1: idx stays 0 and frame_done pulses every REFRESH_DIV cycles.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - segment bit-index constants (SEG_A..SEG_G);
  - a function seg7_encode(nibble) returning active-high segments.
- One sub-module: hex_to_seg7, the combinational nibble-to-7-bit decoder using the package table, instantiated once on the muxed digit.
- Top-level contents: divider, scanner, pending/display registers, blanking logic, output registers.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GHOST_CYCLES=1, both active-low):
- Reset:
  - Stimulus: rst held 3 cycles, then released.
  - Response during reset: an=1111, seg=1111111, dp=1.
  - Response after release: first slot shows digit 0 as 0000001 with an=1110 from its 2nd cycle; frame_done first pulses 16 cycles after release.
- Scan:
  - Stimulus: load digits_in=16'h12AF, dp_in=4'b0100.
  - Response: after the next frame_done, slots show F(0111000,an=1110), A(0001000,an=1101), 2(0010010,an=1011,dp=0), 1(1001111,an=0111).
- Ghost:
  - Stimulus: observe every slot start.
  - Response: first cycle of each slot has an=1111.
- Tear-free:
  - Stimulus: load 16'h8888 mid-frame.
  - Response: the remaining slots of the current frame still show old values; 8888 appears from the next frame.
- Coincident load with frame_done:
  - Stimulus: load 16'h0005 on the frame_done cycle.
  - Response: 0005 is displayed in the immediately following frame.
- Blanking:
  - Stimulus 1: blank_lz=1, value 16'h0050.
  - Response 1: digits 3 and 2 unlit (seg=1111111); digits 1 and 0 show 5 and 0.
  - Stimulus 2: value 16'h0000.
  - Response 2: only digit 0 lit, showing 0.
